// File: rtl/disp_page_scan.sv
// disp_page_scan: multi-page 7-segment scan engine with key / timed page select and digit blink.
// Optional macro DISP_AUTO_ROTATE_EN builds the timed page rotation (dwell counter).
module disp_page_scan #(
  parameter int  NUM_DIGITS   = 8,
  parameter int  NUM_PAGES    = 4,
  parameter int  SCAN_DIV     = 50000,
  parameter int  BLINK_FRAMES = 62,
  parameter int  ROTATE_SEC   = 3,
  localparam int PW           = $clog2(NUM_PAGES)
) (
  input  logic                              CLK_50,
  input  logic                              CR,
  input  logic [NUM_PAGES*NUM_DIGITS*4-1:0] page_data,
  input  logic [NUM_DIGITS-1:0]             blink_mask,
  input  logic                              page_next,
  input  logic                              auto_rotate,
  input  logic                              sec_tick,
  output logic [NUM_DIGITS-1:0]             dig,
  output logic [7:0]                        seg,
  output logic [PW-1:0]                     page
);

  localparam int CW  = $clog2(SCAN_DIV);
  localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BFRM_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [PW-1:0] PAGE_LAST = PW'(NUM_PAGES - 1);

  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0: seg_decode = 8'hC0;
      4'h1: seg_decode = 8'hF9;
      4'h2: seg_decode = 8'hA4;
      4'h3: seg_decode = 8'hB0;
      4'h4: seg_decode = 8'h99;
      4'h5: seg_decode = 8'h92;
      4'h6: seg_decode = 8'h82;
      4'h7: seg_decode = 8'hF8;
      4'h8: seg_decode = 8'h80;
      4'h9: seg_decode = 8'h90;
      4'hA: seg_decode = 8'h88;
      4'hB: seg_decode = 8'h83;
      4'hC: seg_decode = 8'hC6;
      4'hD: seg_decode = 8'hA1;
      4'hE: seg_decode = 8'h86;
      default: seg_decode = 8'hFF;  // F is the blank separator
    endcase
  endfunction

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [PW-1:0]         sel_page_q, sel_page_d;
  logic [PW-1:0]         disp_page_q, disp_page_d;
  logic [BW-1:0]         bfrm_q, bfrm_d;
  logic                  phase_q, phase_d;
  logic                  page_next_q, page_next_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;
  logic [7:0]            seg_q, seg_d;

  logic       key_edge, rot_step, advance, cnt_wrap, frame_start, blank;
  logic [3:0] nib;

  assign key_edge = page_next & ~page_next_q;

`ifdef DISP_AUTO_ROTATE_EN
  localparam int DWW = (ROTATE_SEC > 1) ? $clog2(ROTATE_SEC) : 1;
  localparam logic [DWW-1:0] DWELL_LAST = DWW'(ROTATE_SEC - 1);

  logic [DWW-1:0] dwell_q, dwell_d;

  always_comb begin
    rot_step = auto_rotate & sec_tick & (dwell_q == DWELL_LAST);
    dwell_d  = dwell_q;
    // A key press restarts the dwell so the chosen page gets a full showing.
    if (!auto_rotate || key_edge || rot_step) dwell_d = '0;
    else if (sec_tick)                        dwell_d = dwell_q + DWW'(1);
  end

  always_ff @(posedge CLK_50 or posedge CR) begin
    if (CR) dwell_q <= '0;
    else    dwell_q <= dwell_d;
  end
`else
  logic unused_rotate;
  assign unused_rotate = auto_rotate ^ sec_tick;
  assign rot_step      = 1'b0;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    sel_page_d  = sel_page_q;
    disp_page_d = disp_page_q;
    bfrm_d      = bfrm_q;
    phase_d     = phase_q;
    page_next_d = page_next;
    dig_d       = '1;
    nib         = '0;
    blank       = 1'b0;

    cnt_wrap    = (cnt_q == CNT_LAST);
    frame_start = cnt_wrap && (idx_q == IDX_LAST);
    advance     = key_edge | rot_step;

    if (cnt_wrap) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    // Key and rotate in the same cycle collapse into a single advance.
    if (advance) sel_page_d = (sel_page_q == PAGE_LAST) ? '0 : sel_page_q + PW'(1);

    if (frame_start) disp_page_d = sel_page_q;

    if (advance) begin
      bfrm_d  = '0;
      phase_d = 1'b0;
    end else if (frame_start) begin
      if (bfrm_q == BFRM_LAST) begin
        bfrm_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bfrm_d = bfrm_q + BW'(1);
      end
    end

    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (idx_q == IW'(d)) begin
        dig_d[d] = 1'b0;
        blank    = phase_q & blink_mask[d];
        for (int p = 0; p < NUM_PAGES; p++)
          if (disp_page_q == PW'(p)) nib = page_data[(p*NUM_DIGITS+d)*4 +: 4];
      end
    end
    seg_d = blank ? 8'hFF : seg_decode(nib);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK_50 or posedge CR) begin
    if (CR) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      sel_page_q  <= '0;
      disp_page_q <= '0;
      bfrm_q      <= '0;
      phase_q     <= 1'b0;
      page_next_q <= 1'b0;
      dig_q       <= '1;
      seg_q       <= 8'hFF;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sel_page_q  <= sel_page_d;
      disp_page_q <= disp_page_d;
      bfrm_q      <= bfrm_d;
      phase_q     <= phase_d;
      page_next_q <= page_next_d;
      dig_q       <= dig_d;
      seg_q       <= seg_d;
    end
  end

  assign dig  = dig_q;
  assign seg  = seg_q;
  assign page = sel_page_q;

endmodule

// File: tb/tb_disp_page_scan.sv
// Self-checking bench for disp_page_scan: directed scenarios plus random traffic vs a frame-level model.
// Expected rotation behaviour follows DISP_AUTO_ROTATE_EN, the same macro the RTL is built with.
module tb_disp_page_scan;

  localparam int ND = 4;
  localparam int NP = 3;
  localparam int SD = 4;
  localparam int BF = 2;
  localparam int RS = 2;
  localparam int PW = $clog2(NP);
  localparam int FRAME = ND * SD;

`ifdef DISP_AUTO_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              cr;
  logic [NP*ND*4-1:0] page_data;
  logic [ND-1:0]     blink_mask;
  logic              page_next, auto_rotate, sec_tick;
  logic [ND-1:0]     dig;
  logic [7:0]        seg;
  logic [PW-1:0]     page;

  disp_page_scan #(
    .NUM_DIGITS(ND), .NUM_PAGES(NP), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .ROTATE_SEC(RS)
  ) dut (
    .CLK_50(clk), .CR(cr), .page_data(page_data), .blink_mask(blink_mask),
    .page_next(page_next), .auto_rotate(auto_rotate), .sec_tick(sec_tick),
    .dig(dig), .seg(seg), .page(page)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: time since reset, page chosen, page on display, frames shown since last page change.
  int         m_edges, m_sel, m_disp, m_frames, m_secs;
  bit         m_key_prev;
  logic [3:0] e_dig;
  logic [7:0] e_seg;

  function automatic logic [7:0] seg_of(input logic [3:0] n);
    logic [7:0] tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'hFF};
    return tab[n];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_edges = 0; m_sel = 0; m_disp = 0; m_frames = 0; m_secs = 0; m_key_prev = 1'b0;
    e_dig = 4'hF; e_seg = 8'hFF;
  endtask

  // Applies one clock edge worth of behaviour, using the inputs present at that edge.
  task automatic model_edge();
    int  slot, phase;
    bit  key, rot, fstart;
    logic [3:0] n;
    m_edges++;
    slot  = ((m_edges - 1) / SD) % ND;
    phase = (m_frames / BF) % 2;
    n     = page_data[(m_disp*ND + slot)*4 +: 4];
    e_dig = ~(4'b0001 << slot);
    e_seg = (phase == 1 && blink_mask[slot]) ? 8'hFF : seg_of(n);
    key   = page_next && !m_key_prev;
    m_key_prev = page_next;
    rot    = ROT_EN && auto_rotate && sec_tick && (m_secs + 1 == RS);
    fstart = (m_edges % FRAME) == 0;
    if (fstart) m_disp = m_sel;
    if (key || rot) begin
      m_sel    = (m_sel + 1) % NP;
      m_frames = 0;
    end else if (fstart) begin
      m_frames++;
    end
    if (!ROT_EN || !auto_rotate || key || rot) m_secs = 0;
    else if (sec_tick)                         m_secs++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("dig", 32'(dig), 32'(e_dig));
    check("seg", 32'(seg), 32'(e_seg));
    check("page", 32'(page), 32'(m_sel));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic key_pulse();
    page_next = 1'b1; step();
    page_next = 1'b0; step();
  endtask

  task automatic tick_pulse();
    sec_tick = 1'b1; step();
    sec_tick = 1'b0; steps(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rnd_page;
    bit          found;
    int          page_before;
    rnd_page    = 16'($urandom);
    page_data   = {rnd_page, 16'hFFF0, 16'h1234};
    blink_mask  = '0;
    page_next   = 1'b0;
    auto_rotate = 1'b0;
    sec_tick    = 1'b0;
    cr          = 1'b1;
    model_reset();
    #12;
    check("reset_dig", 32'(dig), 32'hF);
    check("reset_seg", 32'(seg), 32'hFF);
    check("reset_page", 32'(page), 32'h0);
    @(negedge clk);
    cr = 1'b0;

    // Scan of page 0: first edge shows digit 0 = nibble 4.
    step();
    check("first_dig", 32'(dig), 32'hE);
    check("first_seg", 32'(seg), 32'h99);
    steps(2 * FRAME - 1);

    // Key select mid-frame; page moves next cycle, display waits for frame start.
    steps(6);
    page_next = 1'b1; step();
    check("key1_page", 32'(page), 32'h1);
    page_next = 1'b0;
    steps(2 * FRAME);
    key_pulse();
    steps(5);
    key_pulse();
    check("key3_page", 32'(page), 32'h0);
    steps(FRAME);

    // Auto-rotate: four ticks, then a key edge coincident with a rotate step.
    auto_rotate = 1'b1;
    for (int i = 0; i < 4; i++) tick_pulse();
    check("rot_page", 32'(page), ROT_EN ? 32'h2 : 32'h0);
    tick_pulse();
    page_before = int'(page);
    page_next = 1'b1; sec_tick = 1'b1; step();
    check("coincident_step", 32'(page), 32'((page_before + 1) % NP));
    page_next = 1'b0; sec_tick = 1'b0;
    steps(FRAME);
    auto_rotate = 1'b0;

    // Blink on digit 1 over several half-periods, then a page change mid-blink.
    blink_mask = 4'b0010;
    steps(6 * FRAME + 5);
    key_pulse();
    steps(3 * FRAME);

    // Reset while digit 2 is displayed.
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      step();
      if (dig == 4'b1011) found = 1'b1;
    end
    check("reach_digit2", 32'(found), 32'h1);
    cr = 1'b1;
    #1;
    model_reset();
    check("midreset_dig", 32'(dig), 32'hF);
    check("midreset_seg", 32'(seg), 32'hFF);
    check("midreset_page", 32'(page), 32'h0);
    @(negedge clk);
    cr = 1'b0;
    step();
    check("restart_dig", 32'(dig), 32'hE);

    // Ten ticks with rotation requested; only the macro build may move the page.
    auto_rotate = 1'b1;
    for (int i = 0; i < 10; i++) tick_pulse();
`ifndef DISP_AUTO_ROTATE_EN
    check("no_rotate_page", 32'(page), 32'h0);
`endif
    auto_rotate = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0)  blink_mask = 4'($urandom);
      if (i % 120 == 0) page_data  = {16'($urandom), 16'($urandom), 16'($urandom)};
      if (i % 80 == 0)  auto_rotate = 1'($urandom);
      page_next = ($urandom_range(0, 7) == 0) ? ~page_next : page_next;
      sec_tick  = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
